// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU op encodings, issue packet, register constants.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_op_t;

    // Fully resolved op as handed to the ALU.
    typedef struct packed {
        alu_op_t           aluop;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [REG_W-1:0]  rd;
    } issue_pkt_t;

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready buffer: main (output) register plus one skid
// register, so in_ready can be a flop while sustaining one transfer per cycle.
module skid_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic clock,
    input  logic nReset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_nxt;
    T       main_q, skid_q;
    logic   accept;
    logic   load_main_in, load_main_skid, load_skid;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    // Next-state and register-load selection; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (out_ready) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register; in_ready looks ahead at the next state so it is a flop.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    // Data registers: main loads from input or from skid, skid only from input.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute stage: resolves A/B operands with EX/WB forwarding at
// capture time and holds them in a skid buffer in front of the ALU.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int DWIDTH = XLEN,
    parameter int RWIDTH = REG_W
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_aluop,
    input  logic [RWIDTH-1:0] in_rs1,
    input  logic [RWIDTH-1:0] in_rs2,
    input  logic [DWIDTH-1:0] in_rs1_val,
    input  logic [DWIDTH-1:0] in_rs2_val,
    input  logic [DWIDTH-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              in_use_pc,
    input  logic [DWIDTH-1:0] in_pc,
    input  logic [RWIDTH-1:0] in_rd,
    input  logic              ex_wen,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic [DWIDTH-1:0] ex_data,
    input  logic              wb_wen,
    input  logic [RWIDTH-1:0] wb_rd,
    input  logic [DWIDTH-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_aluop,
    output logic [DWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_b,
    output logic [RWIDTH-1:0] out_rd
);

    // x0 always reads zero; the younger EX result wins over WB.
    function automatic logic [DWIDTH-1:0] fwd(
        input logic [RWIDTH-1:0] rs,
        input logic [DWIDTH-1:0] rf_val,
        input logic              exw,
        input logic [RWIDTH-1:0] exr,
        input logic [DWIDTH-1:0] exd,
        input logic              wbw,
        input logic [RWIDTH-1:0] wbr,
        input logic [DWIDTH-1:0] wbd
    );
        if (rs == REG_ZERO)          return '0;
        if (exw && (exr == rs))      return exd;
        if (wbw && (wbr == rs))      return wbd;
        return rf_val;
    endfunction

    issue_pkt_t in_pkt, out_pkt;

    // Operand resolution on the incoming op; captured values are final.
    always_comb begin
        in_pkt       = '0;
        in_pkt.aluop = alu_op_t'(in_aluop);
        in_pkt.rd    = in_rd;
        in_pkt.a     = in_use_pc ? in_pc
                     : fwd(in_rs1, in_rs1_val, ex_wen, ex_rd, ex_data, wb_wen, wb_rd, wb_data);
        in_pkt.b     = in_use_imm ? in_imm
                     : fwd(in_rs2, in_rs2_val, ex_wen, ex_rd, ex_data, wb_wen, wb_rd, wb_data);
    end

    skid_buffer #(.T(issue_pkt_t)) u_skid (
        .clock     (clock),
        .nReset    (nReset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pkt)
    );

    assign out_aluop = out_pkt.aluop;
    assign out_a     = out_pkt.a;
    assign out_b     = out_pkt.b;
    assign out_rd    = out_pkt.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: operand-resolution vector table plus
// hand-written backpressure, throughput, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clock, nReset, flush;
    logic        in_valid, in_ready;
    logic [3:0]  in_aluop;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
    logic        in_use_imm, in_use_pc;
    logic        ex_wen, wb_wen;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_data, wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_aluop;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;

    alu_issue_stage dut (
        .clock(clock), .nReset(nReset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_pc(in_pc),
        .in_rd(in_rd), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  aluop;
        logic [4:0]  rs1;  logic [31:0] rs1v;
        logic [4:0]  rs2;  logic [31:0] rs2v;
        logic [31:0] imm;  logic use_imm;
        logic [31:0] pc;   logic use_pc;
        logic [4:0]  rd;
        logic exw; logic [4:0] exr; logic [31:0] exd;
        logic wbw; logic [4:0] wbr; logic [31:0] wbd;
        logic [31:0] ea, eb;
    } vec_t;

    vec_t tbl [8];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] got[$];
    int          got_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    // An output transfer happens at the next rising edge if valid&&ready now.
    always @(negedge clock)
        if (nReset && out_valid && out_ready) begin
            got.push_back(out_a);
            got_cyc.push_back(cyc);
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [3:0] aluop, input logic [4:0] rs1, input logic [31:0] rs1v,
        input logic [4:0] rs2, input logic [31:0] rs2v, input logic [31:0] imm, input logic use_imm,
        input logic [31:0] pc, input logic use_pc, input logic [4:0] rd,
        input logic exw, input logic [4:0] exr, input logic [31:0] exd,
        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
        input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.aluop = aluop; v.rs1 = rs1; v.rs1v = rs1v; v.rs2 = rs2; v.rs2v = rs2v;
        v.imm = imm; v.use_imm = use_imm; v.pc = pc; v.use_pc = use_pc; v.rd = rd;
        v.exw = exw; v.exr = exr; v.exd = exd; v.wbw = wbw; v.wbr = wbr; v.wbd = wbd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_aluop = v.aluop; in_rs1 = v.rs1; in_rs1_val = v.rs1v;
        in_rs2 = v.rs2; in_rs2_val = v.rs2v; in_imm = v.imm; in_use_imm = v.use_imm;
        in_pc = v.pc; in_use_pc = v.use_pc; in_rd = v.rd;
        ex_wen = v.exw; ex_rd = v.exr; ex_data = v.exd;
        wb_wen = v.wbw; wb_rd = v.wbr; wb_data = v.wbd;
    endtask

    // Plain op tagged by its A value (rs1=x1 read straight from the RF).
    task automatic drive_op(input logic [31:0] tag);
        apply(mk(4'b0000, 5'd1, tag, 5'd2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, tag[4:0],
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, tag, 32'h0));
        in_valid = 1'b1;
    endtask

    initial begin
        //          op     rs1    rs1v          rs2    rs2v          imm           ui    pc          up    rd     exw   exr    exd           wbw   wbr    wbd           ea            eb
        tbl[0] = mk(4'h0, 5'd1, 32'd5,        5'd2, 32'd7,        32'h0,        1'b0, 32'h0,      1'b0, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd5,        32'd7);
        tbl[1] = mk(4'h8, 5'd4, 32'd1,        5'd5, 32'd9,        32'h0,        1'b0, 32'h0,      1'b0, 5'd6, 1'b1, 5'd4, 32'd3,        1'b1, 5'd4, 32'd2,        32'd3,        32'd9);
        tbl[2] = mk(4'hC, 5'd4, 32'd1,        5'd5, 32'd9,        32'h0,        1'b0, 32'h0,      1'b0, 5'd6, 1'b0, 5'd4, 32'd3,        1'b1, 5'd4, 32'd2,        32'd2,        32'd9);
        tbl[3] = mk(4'hE, 5'd0, 32'h55,       5'd0, 32'h66,       32'h0,        1'b0, 32'h0,      1'b0, 5'd7, 1'b1, 5'd0, 32'h77,       1'b1, 5'd0, 32'h88,       32'h0,        32'h0);
        tbl[4] = mk(4'h1, 5'd1, 32'd10,       5'd2, 32'd20,       32'hFFFF_FFFC, 1'b1, 32'h0,     1'b0, 5'd8, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd10,       32'hFFFF_FFFC);
        tbl[5] = mk(4'h0, 5'd1, 32'd10,       5'd2, 32'd20,       32'h0000_0004, 1'b1, 32'h100,   1'b1, 5'd9, 1'b1, 5'd1, 32'hDEAD,     1'b0, 5'd0, 32'h0,        32'h100,      32'h4);
        tbl[6] = mk(4'hB, 5'd6, 32'h11,       5'd8, 32'h22,       32'h0,        1'b0, 32'h0,      1'b0, 5'd31, 1'b1, 5'd7, 32'hAA,      1'b1, 5'd8, 32'hBB,       32'h11,       32'hBB);
        tbl[7] = mk(4'h6, 5'd9, 32'h33,       5'd31, 32'h44,      32'h0,        1'b0, 32'h0,      1'b0, 5'd1, 1'b0, 5'd9, 32'hCC,       1'b1, 5'd31, 32'hEE,      32'h33,       32'hEE);

        nReset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        apply(tbl[0]);
        repeat (2) @(posedge clock);
        #1;
        chk("reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset outputs", {out_aluop, out_a, out_rd}, 64'd0);
        chk("reset out_b", {32'b0, out_b}, 64'd0);
        nReset = 1'b1;
        tick();

        // Operand-resolution table, streaming at full rate.
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            apply(tbl[i]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d valid", i), {63'b0, out_valid}, 64'd1);
            chk($sformatf("vec%0d a", i), {32'b0, out_a}, {32'b0, tbl[i].ea});
            chk($sformatf("vec%0d b", i), {32'b0, out_b}, {32'b0, tbl[i].eb});
            chk($sformatf("vec%0d aluop/rd", i), {55'b0, out_aluop, out_rd}, {55'b0, tbl[i].aluop, tbl[i].rd});
        end
        in_valid = 1'b0;
        tick();
        chk("drain valid", {63'b0, out_valid}, 64'd0);

        // Backpressure: three ops, sink stalled for three edges.
        got.delete(); got_cyc.delete();
        out_ready = 1'b0;
        drive_op(32'h101); tick();
        chk("bp ready after 1st", {63'b0, in_ready}, 64'd1);
        drive_op(32'h102); tick();
        chk("bp ready after 2nd", {63'b0, in_ready}, 64'd0);
        chk("bp head held", {32'b0, out_a}, 64'h101);
        drive_op(32'h103); tick();
        chk("bp still full", {63'b0, in_ready}, 64'd0);
        chk("bp head stable", {32'b0, out_a}, 64'h101);
        out_ready = 1'b1;
        tick();
        chk("bp ready reopens", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("bp count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("bp order %0d", i), {32'b0, got[i]}, 64'(32'h101 + i));

        // Throughput: ten back-to-back ops with the sink always ready.
        got.delete(); got_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tp ready %0d", i), {63'b0, in_ready}, 64'd1);
            drive_op(32'h200 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("tp count", 64'(got.size()), 64'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk($sformatf("tp data %0d", i), {32'b0, got[i]}, 64'(32'h200 + i));
            chk($sformatf("tp cycle %0d", i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
        end

        // Flush from the two-entry state with a new op presented.
        got.delete(); got_cyc.delete();
        out_ready = 1'b0;
        drive_op(32'h301); tick();
        drive_op(32'h302); tick();
        chk("fl full", {63'b0, in_ready}, 64'd0);
        drive_op(32'h303); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl out_valid", {63'b0, out_valid}, 64'd0);
        chk("fl in_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl nothing emerges", 64'(got.size()), 64'd0);
        drive_op(32'h304); tick();
        in_valid = 1'b0;
        chk("fl after op", {32'b0, out_a}, 64'h304);
        tick();
        chk("fl after count", 64'(got.size()), 64'd1);

        // Asynchronous reset between edges while two ops are held.
        out_ready = 1'b0;
        drive_op(32'h401); tick();
        drive_op(32'h402); tick();
        in_valid = 1'b0;
        #2 nReset = 1'b0;
        #1;
        chk("async valid", {63'b0, out_valid}, 64'd0);
        chk("async ready", {63'b0, in_ready}, 64'd1);
        chk("async outputs", {out_aluop, out_a, out_rd}, 64'd0);
        chk("async out_b", {32'b0, out_b}, 64'd0);
        #2 nReset = 1'b1;
        tick();
        chk("post reset empty", {63'b0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
